// File: rtl/spi_frame_loader_if.sv
// Bus bundle between the SPI slave byte port, BRAM port B and the frame loader.
// The loader uses the slave modport; the environment (SPI slave + BRAM) uses master.
interface spi_frame_loader_if #(
    parameter int unsigned ADDRESS_WIDTH = 13
);
    logic [7:0]               spi_dout;
    logic                     spi_done;
    logic                     spi_selected;
    logic [7:0]               spi_din;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [7:0]               mem_din;
    logic [7:0]               mem_dout;
    logic                     frame_commit;
    logic                     busy;
    logic                     err_cmd;

    modport slave (
        input  spi_dout, spi_done, spi_selected, mem_dout,
        output spi_din, mem_we, mem_addr, mem_din, frame_commit, busy, err_cmd
    );

    modport master (
        output spi_dout, spi_done, spi_selected, mem_dout,
        input  spi_din, mem_we, mem_addr, mem_din, frame_commit, busy, err_cmd
    );
endinterface

// File: rtl/spi_frame_loader.sv
// Host command parser: cmd byte, 16-bit address, data stream -> BRAM writes (optional readback).
// Readback path (cmd 0x02, prefetching READ state) is built only with SPI_FRAME_LOADER_READBACK_EN.
module spi_frame_loader #(
    parameter int unsigned ADDRESS_WIDTH = 13
) (
    input logic                 clk,
    input logic                 rst_n,
    spi_frame_loader_if.slave   bus_io
);
    typedef enum logic [2:0] {
        StIdle, StCmd, StAddrHi, StAddrLo, StWrite, StDiscard
`ifdef SPI_FRAME_LOADER_READBACK_EN
        , StRead
`endif
    } state_e;

    localparam logic [ADDRESS_WIDTH-1:0] AddrOne = 1;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]               addr_hi_q, addr_hi_d;
    logic                     wrote_q, wrote_d;
    logic                     err_q, err_d;
    logic                     commit_q, commit_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]               mem_din_q, mem_din_d;
`ifdef SPI_FRAME_LOADER_READBACK_EN
    logic                     rd_mode_q, rd_mode_d;
    // Two-stage prefetch: address issued -> BRAM data valid -> captured into spi_din.
    logic                     pf1_q, pf1_d, pf2_q, pf2_d;
    logic [7:0]               spi_din_q, spi_din_d;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        addr_hi_d  = addr_hi_q;
        wrote_d    = wrote_q;
        err_d      = err_q;
        commit_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
`ifdef SPI_FRAME_LOADER_READBACK_EN
        rd_mode_d  = rd_mode_q;
        pf1_d      = 1'b0;
        pf2_d      = pf1_q;
        spi_din_d  = spi_din_q;
`endif
        case (state_q)
            StIdle: begin
                if (wrote_q) begin
                    commit_d = 1'b1;
                    wrote_d  = 1'b0;
                end
                if (bus_io.spi_selected) begin
                    state_d = StCmd;
                    wrote_d = 1'b0;
                end
            end
            StCmd: begin
                if (bus_io.spi_done) begin
                    case (bus_io.spi_dout)
                        8'h01: begin
                            state_d = StAddrHi;
`ifdef SPI_FRAME_LOADER_READBACK_EN
                            rd_mode_d = 1'b0;
`endif
                        end
`ifdef SPI_FRAME_LOADER_READBACK_EN
                        8'h02: begin
                            state_d   = StAddrHi;
                            rd_mode_d = 1'b1;
                        end
`endif
                        default: begin
                            state_d = StDiscard;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            StAddrHi: begin
                if (bus_io.spi_done) begin
                    addr_hi_d = bus_io.spi_dout;
                    state_d   = StAddrLo;
                end
            end
            StAddrLo: begin
                if (bus_io.spi_done) begin
                    // Cast drops address bits at or above ADDRESS_WIDTH.
                    addr_d  = ADDRESS_WIDTH'({addr_hi_q, bus_io.spi_dout});
                    state_d = StWrite;
`ifdef SPI_FRAME_LOADER_READBACK_EN
                    if (rd_mode_q) begin
                        state_d    = StRead;
                        mem_addr_d = ADDRESS_WIDTH'({addr_hi_q, bus_io.spi_dout});
                        pf1_d      = 1'b1;
                    end
`endif
                end
            end
            StWrite: begin
                if (bus_io.spi_done) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = addr_q;
                    mem_din_d  = bus_io.spi_dout;
                    addr_d     = addr_q + AddrOne;
                    wrote_d    = 1'b1;
                end
            end
`ifdef SPI_FRAME_LOADER_READBACK_EN
            StRead: begin
                if (bus_io.spi_done) begin
                    addr_d     = addr_q + AddrOne;
                    mem_addr_d = addr_q + AddrOne;
                    pf1_d      = 1'b1;
                end
            end
`endif
            StDiscard: ;
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && !bus_io.spi_selected) begin
            state_d = StIdle;
        end

`ifdef SPI_FRAME_LOADER_READBACK_EN
        if (state_q != StRead) begin
            spi_din_d = 8'h00;
        end else if (pf2_q) begin
            spi_din_d = bus_io.mem_dout;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            addr_hi_q  <= 8'h00;
            wrote_q    <= 1'b0;
            err_q      <= 1'b0;
            commit_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= 8'h00;
`ifdef SPI_FRAME_LOADER_READBACK_EN
            rd_mode_q  <= 1'b0;
            pf1_q      <= 1'b0;
            pf2_q      <= 1'b0;
            spi_din_q  <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            addr_hi_q  <= addr_hi_d;
            wrote_q    <= wrote_d;
            err_q      <= err_d;
            commit_q   <= commit_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
`ifdef SPI_FRAME_LOADER_READBACK_EN
            rd_mode_q  <= rd_mode_d;
            pf1_q      <= pf1_d;
            pf2_q      <= pf2_d;
            spi_din_q  <= spi_din_d;
`endif
        end
    end

`ifdef SPI_FRAME_LOADER_READBACK_EN
    assign bus_io.spi_din = (state_q == StRead) ? spi_din_q : 8'h00;
`else
    logic unused_mem_dout;
    assign unused_mem_dout = ^bus_io.mem_dout;
    assign bus_io.spi_din  = 8'h00;
`endif

    assign bus_io.mem_we       = mem_we_q;
    assign bus_io.mem_addr     = mem_addr_q;
    assign bus_io.mem_din      = mem_din_q;
    assign bus_io.frame_commit = commit_q;
    assign bus_io.busy         = (state_q != StIdle);
    assign bus_io.err_cmd      = err_q;
endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader: table of host transactions plus hand-written corner cases.
module tb_spi_frame_loader;
    logic clk;
    logic rst_n;

    spi_frame_loader_if #(.ADDRESS_WIDTH(13)) bus ();

    spi_frame_loader #(.ADDRESS_WIDTH(13)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM port B model with write log and commit counter.
    logic [7:0]  ram [0:8191];
    logic [12:0] log_a[$];
    logic [7:0]  log_d[$];
    int          commit_cnt = 0;

    always @(posedge clk) begin
        if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_din;
            log_a.push_back(bus.mem_addr);
            log_d.push_back(bus.mem_din);
        end
        bus.mem_dout <= ram[bus.mem_addr];
        if (bus.frame_commit) commit_cnt = commit_cnt + 1;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.spi_dout = b;
        bus.spi_done = 1'b1;
        tick(1);
        bus.spi_done = 1'b0;
        tick(9);
    endtask

    typedef struct packed {
        logic [2:0]  nb;
        logic [7:0]  b0, b1, b2, b3, b4;
        logic [1:0]  nw;
        logic [12:0] wa0;
        logic [7:0]  wd0;
        logic [12:0] wa1;
        logic [7:0]  wd1;
        logic [1:0]  ncommit;
        logic        err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          wbase;
        int          cbase;
        logic [7:0]  bs[5];
        logic [12:0] ea[2];
        logic [7:0]  ed[2];

        vecs[0] = '{3'd5, 8'h01, 8'h00, 8'h10, 8'hAA, 8'hBB,
                    2'd2, 13'h0010, 8'hAA, 13'h0011, 8'hBB, 2'd1, 1'b0};
        vecs[1] = '{3'd5, 8'h01, 8'h1F, 8'hFF, 8'h11, 8'h22,
                    2'd2, 13'h1FFF, 8'h11, 13'h0000, 8'h22, 2'd1, 1'b0};
        vecs[2] = '{3'd2, 8'h7E, 8'h33, 8'h00, 8'h00, 8'h00,
                    2'd0, 13'h0000, 8'h00, 13'h0000, 8'h00, 2'd0, 1'b1};
        vecs[3] = '{3'd2, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
                    2'd0, 13'h0000, 8'h00, 13'h0000, 8'h00, 2'd0, 1'b1};
        vecs[4] = '{3'd4, 8'h01, 8'hFF, 8'hFE, 8'h5A, 8'h00,
                    2'd1, 13'h1FFE, 8'h5A, 13'h0000, 8'h00, 2'd1, 1'b1};
        vecs[5] = '{3'd3, 8'h01, 8'h00, 8'h20, 8'h00, 8'h00,
                    2'd0, 13'h0000, 8'h00, 13'h0000, 8'h00, 2'd0, 1'b1};

        rst_n            = 1'b0;
        bus.spi_dout     = 8'h00;
        bus.spi_done     = 1'b0;
        bus.spi_selected = 1'b0;
        tick(3);
        check("reset mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("reset mem_addr", {19'd0, bus.mem_addr}, 32'd0);
        check("reset mem_din", {24'd0, bus.mem_din}, 32'd0);
        check("reset spi_din", {24'd0, bus.spi_din}, 32'd0);
        check("reset frame_commit", {31'd0, bus.frame_commit}, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset err_cmd", {31'd0, bus.err_cmd}, 32'd0);
        rst_n = 1'b1;
        tick(3);

        for (int i = 0; i < 6; i++) begin
            wbase = log_a.size();
            cbase = commit_cnt;
            bs = '{vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].b4};
            ea = '{vecs[i].wa0, vecs[i].wa1};
            ed = '{vecs[i].wd0, vecs[i].wd1};
            bus.spi_selected = 1'b1;
            tick(3);
            check($sformatf("v%0d busy while selected", i), {31'd0, bus.busy}, 32'd1);
            for (int k = 0; k < int'(vecs[i].nb); k++) send_byte(bs[k]);
            bus.spi_selected = 1'b0;
            tick(6);
            check($sformatf("v%0d write count", i), log_a.size() - wbase, {30'd0, vecs[i].nw});
            for (int j = 0; j < int'(vecs[i].nw); j++) begin
                check($sformatf("v%0d write%0d addr", i, j),
                      (wbase + j < log_a.size()) ? {19'd0, log_a[wbase + j]} : 32'hFFFF_FFFF,
                      {19'd0, ea[j]});
                check($sformatf("v%0d write%0d data", i, j),
                      (wbase + j < log_d.size()) ? {24'd0, log_d[wbase + j]} : 32'hFFFF_FFFF,
                      {24'd0, ed[j]});
            end
            check($sformatf("v%0d commits", i), commit_cnt - cbase, {30'd0, vecs[i].ncommit});
            check($sformatf("v%0d err_cmd", i), {31'd0, bus.err_cmd}, {31'd0, vecs[i].err});
            check($sformatf("v%0d busy after", i), {31'd0, bus.busy}, 32'd0);
        end

        // Reset in the middle of a write burst: outputs clear at once, no commit follows.
        bus.spi_selected = 1'b1;
        tick(3);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h50);
        send_byte(8'h99);
        cbase = commit_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst mem_addr", {19'd0, bus.mem_addr}, 32'd0);
        check("midrst mem_din", {24'd0, bus.mem_din}, 32'd0);
        check("midrst busy", {31'd0, bus.busy}, 32'd0);
        check("midrst err_cmd", {31'd0, bus.err_cmd}, 32'd0);
        bus.spi_selected = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check("midrst no commit", commit_cnt - cbase, 32'd0);

`ifdef SPI_FRAME_LOADER_READBACK_EN
        bus.spi_selected = 1'b1;
        tick(3);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h5C);
        send_byte(8'hC5);
        bus.spi_selected = 1'b0;
        tick(6);
        wbase = log_a.size();
        cbase = commit_cnt;
        bus.spi_selected = 1'b1;
        tick(3);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h05);
        check("read first miso", {24'd0, bus.spi_din}, 32'h5C);
        send_byte(8'h00);
        check("read second miso", {24'd0, bus.spi_din}, 32'hC5);
        send_byte(8'h00);
        bus.spi_selected = 1'b0;
        tick(6);
        check("read no writes", log_a.size() - wbase, 32'd0);
        check("read no commit", commit_cnt - cbase, 32'd0);
        check("read err_cmd", {31'd0, bus.err_cmd}, 32'd0);
        check("read miso idle", {24'd0, bus.spi_din}, 32'd0);
`else
        wbase = log_a.size();
        cbase = commit_cnt;
        bus.spi_selected = 1'b1;
        tick(3);
        send_byte(8'h02);
        check("cmd02 err_cmd", {31'd0, bus.err_cmd}, 32'd1);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h00);
        check("cmd02 miso", {24'd0, bus.spi_din}, 32'd0);
        bus.spi_selected = 1'b0;
        tick(6);
        check("cmd02 no writes", log_a.size() - wbase, 32'd0);
        check("cmd02 no commit", commit_cnt - cbase, 32'd0);
`endif

        // Last data byte arrives in the same cycle as deselect.
        bus.spi_selected = 1'b1;
        tick(3);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h40);
        bus.spi_dout     = 8'h77;
        bus.spi_done     = 1'b1;
        bus.spi_selected = 1'b0;
        tick(1);
        bus.spi_done = 1'b0;
        check("coinc N+1 mem_we", {31'd0, bus.mem_we}, 32'd1);
        check("coinc N+1 mem_addr", {19'd0, bus.mem_addr}, 32'h40);
        check("coinc N+1 mem_din", {24'd0, bus.mem_din}, 32'h77);
        check("coinc N+1 busy", {31'd0, bus.busy}, 32'd0);
        check("coinc N+1 commit", {31'd0, bus.frame_commit}, 32'd0);
        tick(1);
        check("coinc N+2 commit", {31'd0, bus.frame_commit}, 32'd1);
        check("coinc N+2 mem_we", {31'd0, bus.mem_we}, 32'd0);
        tick(1);
        check("coinc N+3 commit", {31'd0, bus.frame_commit}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
